riscv_mem_arbiter: RTL and testbench

Shares the single memory port between the instruction-fetch unit and the LSU data path. Accepts level-held requests from both, grants one at a time, and registers the winning transaction onto the memory bus. It holds that transaction until `mem_ready_i`, then returns read data and a one-cycle ready to the winner. A watchdog aborts any access the memory never completes, flagging it with an error.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_mem_arbiter_if.sv | 51 +++++
 rtl/riscv_arb_timer.sv | 43 ++++
 rtl/riscv_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the memory arbiter slice.
//   arb_state_t         - arbiter FSM state encoding
//   ARB_TIMEOUT_DEFAULT - default watchdog limit in cycles
//   MEM_BE_FULL         - byte-enable pattern for full-word fetches
package riscv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_INSTR,
        ARB_DATA
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;
    localparam logic [3:0]  MEM_BE_FULL         = 4'b1111;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: bundles the fetch, LSU and memory-side signals of
// the memory arbiter.
//   slave  - arbiter view: takes requester/memory inputs, drives
//            completions and the registered memory bus
//   master - environment view: requesters plus memory model
interface riscv_mem_arbiter_if;

    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rd_o;
    logic        instr_ready_o;

    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wd_i;
    logic [31:0] data_rd_o;
    logic        data_ready_o;

    logic        err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_rd_o, instr_ready_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wd_i,
        output data_rd_o, data_ready_o,
        output err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_rd_o, instr_ready_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wd_i,
        input  data_rd_o, data_ready_o,
        input  err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );

endinterface

// File: rtl/riscv_arb_timer.sv
// riscv_arb_timer: watchdog counter for an outstanding memory access.
//   clk_i, rst_i - clock, synchronous active-high reset
//   clear_i      - force the count to zero (has priority)
//   enable_i     - advance the count by one this cycle
//   limit_i      - count value at which expire_o asserts
//   expire_o     - count has reached limit_i
module riscv_arb_timer
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and
// the LSU. One access is outstanding at a time; the winning request is
// registered onto the memory bus and held until mem_ready_i or a watchdog
// abort, which completes the access with err_o set.
//   clk_i, rst_i - clock, synchronous active-high reset
//   bus          - riscv_mem_arbiter_if.slave (requesters + memory bus)
// Build option: define RISCV_MEM_ARB_RR_EN to alternate priority on ties;
// otherwise the LSU always wins a tie.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    riscv_mem_arbiter_if.slave         bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;

    logic        busy;
    logic        expire;
    logic        done;
    logic        prefer_instr;
    logic        instr_ready;
    logic        data_ready;
    logic [31:0] instr_rd;
    logic [31:0] data_rd;
    logic        err;

    assign busy = (state_q != ARB_IDLE);
    // A real response in the final watchdog cycle wins over the abort.
    assign done = busy && (bus.mem_ready_i || expire);

    riscv_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!busy),
        .enable_i (busy && !bus.mem_ready_i),
        .limit_i  (LIMIT),
        .expire_o (expire)
    );

`ifdef RISCV_MEM_ARB_RR_EN
    // Remembers whether the LSU won the last access; the fetch side is
    // favoured on the next tie when it did. Reset value favours the LSU.
    logic last_data_q, last_data_d;

    assign prefer_instr = last_data_q;

    always_comb begin
        last_data_d = last_data_q;
        if (done) begin
            last_data_d = (state_q == ARB_DATA);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    assign prefer_instr = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wd_d    = mem_wd_q;
        instr_ready = 1'b0;
        data_ready  = 1'b0;
        instr_rd    = '0;
        data_rd     = '0;
        err         = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.data_req_i && !(bus.instr_req_i && prefer_instr)) begin
                    state_d    = ARB_DATA;
                    mem_req_d  = 1'b1;
                    mem_we_d   = bus.data_we_i;
                    mem_be_d   = bus.data_be_i;
                    mem_addr_d = bus.data_addr_i;
                    mem_wd_d   = bus.data_wd_i;
                end else if (bus.instr_req_i) begin
                    state_d    = ARB_INSTR;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = MEM_BE_FULL;
                    mem_addr_d = bus.instr_addr_i;
                    mem_wd_d   = '0;
                end
            end
            ARB_INSTR, ARB_DATA: begin
                if (done) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    err       = !bus.mem_ready_i;
                    if (state_q == ARB_INSTR) begin
                        instr_ready = 1'b1;
                        instr_rd    = bus.mem_ready_i ? bus.mem_rd_i : '0;
                    end else begin
                        data_ready  = 1'b1;
                        data_rd     = bus.mem_ready_i ? bus.mem_rd_i : '0;
                    end
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign bus.mem_req_o     = mem_req_q;
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_be_o      = mem_be_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_wd_o      = mem_wd_q;
    assign bus.instr_ready_o = instr_ready;
    assign bus.instr_rd_o    = instr_rd;
    assign bus.data_ready_o  = data_ready;
    assign bus.data_rd_o     = data_rd;
    assign bus.err_o         = err;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed self-checking bench for riscv_mem_arbiter
// with a 4-cycle watchdog. Inputs change 1 time unit after the rising edge
// and outputs are sampled in the same window, so "cycle N" below is the
// clock period beginning at the N-th edge after the request was applied.
module tb_riscv_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    riscv_mem_arbiter_if bus_if ();

    riscv_mem_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus_if.instr_req_i  = 1'b0;
        bus_if.instr_addr_i = '0;
        bus_if.data_req_i   = 1'b0;
        bus_if.data_we_i    = 1'b0;
        bus_if.data_be_i    = '0;
        bus_if.data_addr_i  = '0;
        bus_if.data_wd_i    = '0;
        bus_if.mem_ready_i  = 1'b0;
        bus_if.mem_rd_i     = 32'hAAAA_5555;
    endtask

    initial begin
        quiet_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_mem_req", bus_if.mem_req_o, 0);
        check("rst_mem_addr", bus_if.mem_addr_o, 0);
        check("rst_mem_be", bus_if.mem_be_o, 0);
        check("rst_ready", {bus_if.instr_ready_o, bus_if.data_ready_o, bus_if.err_o}, 0);
        check("rst_rd", bus_if.data_rd_o | bus_if.instr_rd_o, 0);

        // Lone data write, address changed mid-access, ready in cycle 3
        bus_if.data_req_i  = 1'b1;
        bus_if.data_we_i   = 1'b1;
        bus_if.data_be_i   = 4'b0011;
        bus_if.data_addr_i = 32'h0000_0100;
        bus_if.data_wd_i   = 32'hDEAD_BEEF;
        check("wr_c0_req", bus_if.mem_req_o, 0);
        step(); // cycle 1
        check("wr_c1_req", bus_if.mem_req_o, 1);
        check("wr_c1_we", bus_if.mem_we_o, 1);
        check("wr_c1_be", bus_if.mem_be_o, 4'b0011);
        check("wr_c1_addr", bus_if.mem_addr_o, 32'h0000_0100);
        check("wr_c1_wd", bus_if.mem_wd_o, 32'hDEAD_BEEF);
        check("wr_c1_ready", bus_if.data_ready_o, 0);
        bus_if.data_addr_i = 32'h0000_0200;
        bus_if.data_wd_i   = 32'h1234_5678;
        step(); // cycle 2
        check("wr_c2_addr_hold", bus_if.mem_addr_o, 32'h0000_0100);
        check("wr_c2_wd_hold", bus_if.mem_wd_o, 32'hDEAD_BEEF);
        check("wr_c2_ready", bus_if.data_ready_o, 0);
        check("wr_c2_rd_zero", bus_if.data_rd_o, 0);
        step(); // cycle 3
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rd_i    = 32'h0BAD_F00D;
        #1;
        check("wr_c3_addr_hold", bus_if.mem_addr_o, 32'h0000_0100);
        check("wr_c3_dready", bus_if.data_ready_o, 1);
        check("wr_c3_iready", bus_if.instr_ready_o, 0);
        check("wr_c3_err", bus_if.err_o, 0);
        check("wr_c3_rd", bus_if.data_rd_o, 32'h0BAD_F00D);
        step(); // cycle 4
        quiet_inputs();
        #1;
        check("wr_c4_req", bus_if.mem_req_o, 0);
        check("wr_c4_ready", bus_if.data_ready_o, 0);

        // Lone fetch read, ready in cycle 1
        bus_if.instr_req_i  = 1'b1;
        bus_if.instr_addr_i = 32'h0000_0040;
        step(); // cycle 1
        check("if_c1_req", bus_if.mem_req_o, 1);
        check("if_c1_addr", bus_if.mem_addr_o, 32'h0000_0040);
        check("if_c1_we", bus_if.mem_we_o, 0);
        check("if_c1_be", bus_if.mem_be_o, 4'b1111);
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rd_i    = 32'h0000_0013;
        #1;
        check("if_c1_iready", bus_if.instr_ready_o, 1);
        check("if_c1_rd", bus_if.instr_rd_o, 32'h0000_0013);
        check("if_c1_dready", bus_if.data_ready_o, 0);
        step(); // cycle 2
        quiet_inputs();
        #1;
        check("if_c2_req", bus_if.mem_req_o, 0);
        check("if_c2_rd_zero", bus_if.instr_rd_o, 0);

        // Simultaneous requests held across two accesses
        bus_if.instr_req_i  = 1'b1;
        bus_if.instr_addr_i = 32'h0000_0080;
        bus_if.data_req_i   = 1'b1;
        bus_if.data_be_i    = 4'b1111;
        bus_if.data_addr_i  = 32'h0000_0300;
        step(); // cycle 1
        check("tie1_addr", bus_if.mem_addr_o, 32'h0000_0300);
        bus_if.mem_ready_i = 1'b1;
        #1;
        check("tie1_dready", bus_if.data_ready_o, 1);
        check("tie1_iready", bus_if.instr_ready_o, 0);
        step(); // cycle 2, idle, both still requesting
        bus_if.mem_ready_i = 1'b0;
        #1;
        check("tie_gap_req", bus_if.mem_req_o, 0);
        step(); // cycle 3
        bus_if.mem_ready_i = 1'b1;
        #1;
`ifdef RISCV_MEM_ARB_RR_EN
        check("tie2_addr", bus_if.mem_addr_o, 32'h0000_0080);
        check("tie2_iready", bus_if.instr_ready_o, 1);
        check("tie2_dready", bus_if.data_ready_o, 0);
`else
        check("tie2_addr", bus_if.mem_addr_o, 32'h0000_0300);
        check("tie2_iready", bus_if.instr_ready_o, 0);
        check("tie2_dready", bus_if.data_ready_o, 1);
`endif
        step();
        quiet_inputs();
        step();

        // Watchdog abort with silent memory, stale response afterwards
        bus_if.data_req_i  = 1'b1;
        bus_if.data_be_i   = 4'b1111;
        bus_if.data_addr_i = 32'h0000_0500;
        step(); // cycle 1
        for (int c = 1; c < 4; c++) begin
            check("to_wait_ready", bus_if.data_ready_o, 0);
            step();
        end
        // cycle 4
        check("to_c4_dready", bus_if.data_ready_o, 1);
        check("to_c4_err", bus_if.err_o, 1);
        check("to_c4_rd", bus_if.data_rd_o, 0);
        check("to_c4_iready", bus_if.instr_ready_o, 0);
        step(); // cycle 5
        bus_if.data_req_i = 1'b0;
        #1;
        check("to_c5_req", bus_if.mem_req_o, 0);
        check("to_c5_ready", bus_if.data_ready_o, 0);
        step(); // cycle 6
        bus_if.mem_ready_i = 1'b1;
        #1;
        check("to_c6_stale", {bus_if.instr_ready_o, bus_if.data_ready_o, bus_if.err_o}, 0);
        step(); // cycle 7
        bus_if.mem_ready_i = 1'b0;
        #1;
        check("to_c7_req", bus_if.mem_req_o, 0);

        // Reset in the middle of an access
        bus_if.data_req_i  = 1'b1;
        bus_if.data_addr_i = 32'h0000_0600;
        step(); // cycle 1
        check("rm_c1_req", bus_if.mem_req_o, 1);
        step(); // cycle 2
        rst = 1'b1;
        step(); // cycle 3
        rst = 1'b0;
        #1;
        check("rm_c3_req", bus_if.mem_req_o, 0);
        check("rm_c3_addr", bus_if.mem_addr_o, 0);
        check("rm_c3_ready", {bus_if.instr_ready_o, bus_if.data_ready_o}, 0);
        step(); // cycle 4, request still held -> granted at end of cycle 3
        check("rm_c4_req", bus_if.mem_req_o, 1);
        check("rm_c4_addr", bus_if.mem_addr_o, 32'h0000_0600);
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rd_i    = 32'hCAFE_0001;
        #1;
        check("rm_c4_dready", bus_if.data_ready_o, 1);
        check("rm_c4_rd", bus_if.data_rd_o, 32'hCAFE_0001);
        step();
        quiet_inputs();
        step();

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule
